// File: rtl/uart_alu_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : uart_alu_bridge
//  Description : Collects two operands and an opcode from tagged UART frames,
//                presents them to an external combinational ALU, captures the
//                result and hands it to a UART transmitter.
//
//                Frame format on i_rx_data: {tag[NB_TAG-1:0], payload[NB_DATA-1:0]}
//                  tag 0 -> operand 1, tag 1 -> operand 2,
//                  tag 2 -> opcode (low NB_OP payload bits),
//                  tag 3 -> discard the partially collected set.
//
//  Ports       : i_clk, i_reset (sync, active-high)
//                i_rx_data / i_rx_done    : received frame and its strobe
//                i_tx_busy                : UART transmitter busy
//                i_alu_result             : combinational ALU result
//                o_operand1/2, o_opcode   : registered ALU inputs
//                o_data_ready             : pulse, ALU inputs complete
//                o_tx_data / o_tx_start   : result byte and tx start pulse
//                o_error                  : pulse, frame dropped or timeout
//
//  Build option: define UART_ALU_TIMEOUT_EN to discard a partial operand set
//                after TIMEOUT_CYCLES idle cycles.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_alu_bridge #(
    parameter int  NB_OP          = 6,
    parameter int  NB_DATA        = 8,
    parameter int  NB_TAG         = 2,
    parameter int  TIMEOUT_CYCLES = 1000000,
    localparam int NB_FULL_DATA   = NB_TAG + NB_DATA
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NB_FULL_DATA-1:0] i_rx_data,
    input  logic                    i_rx_done,
    input  logic                    i_tx_busy,
    input  logic [NB_DATA-1:0]      i_alu_result,
    output logic [NB_DATA-1:0]      o_operand1,
    output logic [NB_DATA-1:0]      o_operand2,
    output logic [NB_OP-1:0]        o_opcode,
    output logic                    o_data_ready,
    output logic [NB_DATA-1:0]      o_tx_data,
    output logic                    o_tx_start,
    output logic                    o_error
);

    localparam logic [NB_TAG-1:0] c_TAG_OP1 = NB_TAG'(0);
    localparam logic [NB_TAG-1:0] c_TAG_OP2 = NB_TAG'(1);
    localparam logic [NB_TAG-1:0] c_TAG_OPC = NB_TAG'(2);
    localparam logic [NB_TAG-1:0] c_TAG_CLR = NB_TAG'(3);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_EXEC    = 2'd1,
        S_SEND    = 2'd2,
        S_WAIT_TX = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 flag1_q, flag1_d;
    logic                 flag2_q, flag2_d;
    logic                 flagop_q, flagop_d;
    logic                 seen_busy_q, seen_busy_d;
    logic [NB_DATA-1:0]   operand1_q, operand1_d;
    logic [NB_DATA-1:0]   operand2_q, operand2_d;
    logic [NB_OP-1:0]     opcode_q, opcode_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic                 data_ready_q, data_ready_d;
    logic                 tx_start_q, tx_start_d;
    logic                 error_q, error_d;

    logic [NB_TAG-1:0]    w_tag;
    logic [NB_DATA-1:0]   w_payload;

    assign w_tag     = i_rx_data[NB_FULL_DATA-1 -: NB_TAG];
    assign w_payload = i_rx_data[NB_DATA-1:0];

`ifdef UART_ALU_TIMEOUT_EN
    localparam int               c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic               w_timeout_hit;

    // Idle counter for a partially collected set; any accepted frame
    // restarts it, and it sits at zero whenever there is nothing to time out.
    always_comb begin
        tmo_cnt_d     = tmo_cnt_q;
        w_timeout_hit = 1'b0;
        if ((state_q != S_COLLECT) || i_rx_done || !(flag1_q || flag2_q || flagop_q)) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == c_TMO_LAST) begin
            w_timeout_hit = 1'b1;
            tmo_cnt_d     = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    // Without the timeout a partial set is held indefinitely; TIMEOUT_CYCLES
    // has no hardware behind it in this build.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_d      = state_q;
        flag1_d      = flag1_q;
        flag2_d      = flag2_q;
        flagop_d     = flagop_q;
        seen_busy_d  = seen_busy_q;
        operand1_d   = operand1_q;
        operand2_d   = operand2_q;
        opcode_d     = opcode_q;
        tx_data_d    = tx_data_q;
        data_ready_d = 1'b0;
        tx_start_d   = 1'b0;
        error_d      = 1'b0;

        case (state_q)
            S_COLLECT: begin
                if (i_rx_done) begin
                    case (w_tag)
                        c_TAG_OP1: begin
                            operand1_d = w_payload;
                            flag1_d    = 1'b1;
                        end
                        c_TAG_OP2: begin
                            operand2_d = w_payload;
                            flag2_d    = 1'b1;
                        end
                        c_TAG_OPC: begin
                            opcode_d = w_payload[NB_OP-1:0];
                            flagop_d = 1'b1;
                        end
                        c_TAG_CLR: begin
                            flag1_d  = 1'b0;
                            flag2_d  = 1'b0;
                            flagop_d = 1'b0;
                        end
                        default: ;
                    endcase
                    // The frame that fills the last slot launches execution.
                    if (flag1_d && flag2_d && flagop_d) begin
                        state_d      = S_EXEC;
                        data_ready_d = 1'b1;
                    end
                end
`ifdef UART_ALU_TIMEOUT_EN
                else if (w_timeout_hit) begin
                    flag1_d  = 1'b0;
                    flag2_d  = 1'b0;
                    flagop_d = 1'b0;
                    error_d  = 1'b1;
                end
`endif
            end
            S_EXEC: begin
                // Operands have been stable for a full cycle; capture the ALU.
                tx_data_d = i_alu_result;
                flag1_d   = 1'b0;
                flag2_d   = 1'b0;
                flagop_d  = 1'b0;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (!i_tx_busy) begin
                    tx_start_d  = 1'b1;
                    seen_busy_d = 1'b0;
                    state_d     = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                // Wait for the transmitter to accept (busy high) and then finish.
                if (!seen_busy_q) begin
                    if (i_tx_busy) begin
                        seen_busy_d = 1'b1;
                    end
                end else if (!i_tx_busy) begin
                    seen_busy_d = 1'b0;
                    state_d     = S_COLLECT;
                end
            end
            default: state_d = S_COLLECT;
        endcase

        // Frames arriving while a result is in flight are dropped.
        if (i_rx_done && (state_q != S_COLLECT)) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_COLLECT;
            flag1_q      <= 1'b0;
            flag2_q      <= 1'b0;
            flagop_q     <= 1'b0;
            seen_busy_q  <= 1'b0;
            operand1_q   <= '0;
            operand2_q   <= '0;
            opcode_q     <= '0;
            tx_data_q    <= '0;
            data_ready_q <= 1'b0;
            tx_start_q   <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            flag1_q      <= flag1_d;
            flag2_q      <= flag2_d;
            flagop_q     <= flagop_d;
            seen_busy_q  <= seen_busy_d;
            operand1_q   <= operand1_d;
            operand2_q   <= operand2_d;
            opcode_q     <= opcode_d;
            tx_data_q    <= tx_data_d;
            data_ready_q <= data_ready_d;
            tx_start_q   <= tx_start_d;
            error_q      <= error_d;
        end
    end

    assign o_operand1   = operand1_q;
    assign o_operand2   = operand2_q;
    assign o_opcode     = opcode_q;
    assign o_data_ready = data_ready_q;
    assign o_tx_data    = tx_data_q;
    assign o_tx_start   = tx_start_q;
    assign o_error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_alu_bridge
//  Description : Self-checking bench for uart_alu_bridge. Operand sets come
//                from a vector table; expected tx bytes go into a scoreboard
//                queue and are compared when o_tx_start fires. Hand-written
//                sequences cover overwrite, discard, busy hold-off, dropped
//                frames, reset in WAIT_TX and the partial-set timeout option.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_alu_bridge;

    localparam int c_TIMEOUT = 20;
`ifdef UART_ALU_TIMEOUT_EN
    localparam int c_EXP_ERRORS = 2;
`else
    localparam int c_EXP_ERRORS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] rx_data;
    logic       rx_done;
    logic       tx_busy;
    logic [7:0] alu_result;
    logic [7:0] operand1;
    logic [7:0] operand2;
    logic [5:0] opcode;
    logic       data_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       error;

    always #5 clk = ~clk;

    uart_alu_bridge #(
        .NB_OP         (6),
        .NB_DATA       (8),
        .NB_TAG        (2),
        .TIMEOUT_CYCLES(c_TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_rx_data   (rx_data),
        .i_rx_done   (rx_done),
        .i_tx_busy   (tx_busy),
        .i_alu_result(alu_result),
        .o_operand1  (operand1),
        .o_operand2  (operand2),
        .o_opcode    (opcode),
        .o_data_ready(data_ready),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .o_error     (error)
    );

    // Environment ALU: small opcode set, 8-bit wrapping arithmetic.
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_f(operand1, operand2, opcode);

    int         n_vec   = 0;
    int         n_fail  = 0;
    int         n_ready = 0;
    int         n_start = 0;
    int         n_error = 0;
    logic [7:0] exp_q[$];
    logic [7:0] sb_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulse counters and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (data_ready === 1'b1) n_ready++;
        if (error === 1'b1) n_error++;
        if (tx_start === 1'b1) begin
            n_start++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL tx_unexpected: tx_start with empty scoreboard, tx_data=%02h", tx_data);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_tx_data", 32'(tx_data), 32'(sb_exp));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [1:0] tag, input logic [7:0] pl);
        rx_data = {tag, pl};
        rx_done = 1'b1;
        step(1);
        rx_done = 1'b0;
    endtask

    // Called right after the completing frame's strobe edge. Latency is
    // counted in cycles from the cycle carrying that strobe.
    task automatic wait_start(input string tag);
        int lat;
        check({tag, "/data_ready"}, 32'(data_ready), 32'd1);
        lat = 1;
        while (tx_start !== 1'b1 && lat < 20) begin
            step(1);
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'd3);
    endtask

    task automatic tx_handshake();
        tx_busy = 1'b1;
        step(3);
        tx_busy = 1'b0;
        step(2);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/operand1"}, 32'(operand1), 32'd0);
        check({tag, "/operand2"}, 32'(operand2), 32'd0);
        check({tag, "/opcode"}, 32'(opcode), 32'd0);
        check({tag, "/tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "/data_ready"}, 32'(data_ready), 32'd0);
        check({tag, "/tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "/error"}, 32'(error), 32'd0);
    endtask

    typedef struct packed {
        logic [7:0] op1;
        logic [7:0] op2;
        logic [5:0] opc;
        logic [7:0] exp;
    } vec_t;

    task automatic run_vector(input string tag, input vec_t v);
        int r0;
        r0 = n_ready;
        exp_q.push_back(v.exp);
        send_frame(2'd0, v.op1);
        send_frame(2'd1, v.op2);
        send_frame(2'd2, {2'b00, v.opc});
        wait_start(tag);
        tx_handshake();
        check({tag, "/op1_hold"}, 32'(operand1), 32'(v.op1));
        check({tag, "/op2_hold"}, 32'(operand2), 32'(v.op2));
        check({tag, "/opc_hold"}, 32'(opcode), 32'(v.opc));
        check({tag, "/tx_data_hold"}, 32'(tx_data), 32'(v.exp));
        check({tag, "/ready_pulses"}, 32'(n_ready - r0), 32'd1);
    endtask

    vec_t vecs[6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int r0;
        int s0;
        int e0;
        int n;

        vecs[0] = '{8'h05, 8'h03, 6'h20, 8'h08};
        vecs[1] = '{8'h10, 8'h03, 6'h22, 8'h0D};
        vecs[2] = '{8'hF0, 8'h3C, 6'h24, 8'h30};
        vecs[3] = '{8'hF0, 8'h0F, 6'h25, 8'hFF};
        vecs[4] = '{8'hAA, 8'hFF, 6'h26, 8'h55};
        vecs[5] = '{8'hFF, 8'h01, 6'h20, 8'h00};

        // Reset, with a frame strobe present to show reset wins.
        rst     = 1'b1;
        tx_busy = 1'b0;
        rx_data = {2'd0, 8'h55};
        rx_done = 1'b1;
        step(3);
        check_all_zero("reset");
        rx_done = 1'b0;
        rst     = 1'b0;
        step(2);

        for (int i = 0; i < 6; i++) begin
            run_vector($sformatf("vec%0d", i), vecs[i]);
        end

        // Repeated operand-1 frame overwrites before completion.
        r0 = n_ready;
        exp_q.push_back(8'h80);
        send_frame(2'd0, 8'h01);
        send_frame(2'd0, 8'h7F);
        send_frame(2'd1, 8'h01);
        send_frame(2'd2, 8'h20);
        wait_start("overwrite");
        tx_handshake();
        check("overwrite/operand1", 32'(operand1), 32'h7F);
        check("overwrite/ready_pulses", 32'(n_ready - r0), 32'd1);

        // Tag 3 discards the partial set; it must be rebuilt.
        r0 = n_ready;
        send_frame(2'd0, 8'h11);
        send_frame(2'd1, 8'h22);
        send_frame(2'd3, 8'h00);
        send_frame(2'd2, 8'h20);
        step(3);
        check("discard/no_ready", 32'(n_ready - r0), 32'd0);
        exp_q.push_back(8'h03);
        send_frame(2'd0, 8'h01);
        send_frame(2'd1, 8'h02);
        wait_start("discard");
        tx_handshake();
        check("discard/ready_pulses", 32'(n_ready - r0), 32'd1);

        // Busy transmitter holds off tx_start; a frame meanwhile is dropped.
        s0 = n_start;
        e0 = n_error;
        tx_busy = 1'b1;
        exp_q.push_back(8'h05);
        send_frame(2'd0, 8'h09);
        send_frame(2'd1, 8'h04);
        send_frame(2'd2, 8'h22);
        check("busy/data_ready", 32'(data_ready), 32'd1);
        step(20);
        send_frame(2'd0, 8'h77);
        check("busy/drop_error", 32'(error), 32'd1);
        check("busy/operand1_kept", 32'(operand1), 32'h09);
        step(1);
        check("busy/error_one_cycle", 32'(error), 32'd0);
        step(26);
        check("busy/start_held", 32'(n_start - s0), 32'd0);
        tx_busy = 1'b0;
        step(1);
        check("busy/start_after_release", 32'(tx_start), 32'd1);
        tx_handshake();
        check("busy/error_pulses", 32'(n_error - e0), 32'd1);

        // Reset while waiting on the transmitter aborts everything.
        exp_q.push_back(8'h05);
        send_frame(2'd0, 8'h02);
        send_frame(2'd1, 8'h03);
        send_frame(2'd2, 8'h20);
        wait_start("rst_wait");
        tx_busy = 1'b1;
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_all_zero("rst_wait");
        tx_busy = 1'b0;
        s0 = n_start;
        step(10);
        check("rst_wait/no_start", 32'(n_start - s0), 32'd0);
        run_vector("after_rst", '{8'h21, 8'h21, 6'h20, 8'h42});

`ifdef UART_ALU_TIMEOUT_EN
        // Partial set expires after c_TIMEOUT idle cycles.
        r0 = n_ready;
        send_frame(2'd0, 8'h44);
        n = 0;
        while (error !== 1'b1 && n < 100) begin
            step(1);
            n++;
        end
        check("timeout/cycles", 32'(n), 32'(c_TIMEOUT));
        send_frame(2'd1, 8'h01);
        send_frame(2'd2, 8'h20);
        step(3);
        check("timeout/no_ready", 32'(n_ready - r0), 32'd0);
        send_frame(2'd3, 8'h00);
        step(1);
`else
        // Partial set is held indefinitely.
        r0 = n_ready;
        n  = 0;
        exp_q.push_back(8'h45);
        send_frame(2'd0, 8'h44);
        step(200);
        send_frame(2'd1, 8'h01);
        send_frame(2'd2, 8'h20);
        wait_start("hold");
        tx_handshake();
        check("hold/ready_pulses", 32'(n_ready - r0), 32'd1);
`endif

        step(2);
        check("total_errors", 32'(n_error), 32'(c_EXP_ERRORS));
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
